muldiv_unit: RTL

//  Multi-cycle RV32M/RV64M multiply/divide unit; successor to the fixed 3-cycle MULT block.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M/RV64M multiply/divide unit with tag and flush
module muldiv_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int MULT_LATENCY = 3,
    parameter int TAG_WIDTH    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_N = (W + 2 > MULT_LATENCY) ? W + 2 : MULT_LATENCY;
    localparam int CNT_W = $clog2(CNT_N);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MULT_LATENCY >= 2) ? MULT_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(W);
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [W-1:0]         rem_q;
    logic [1:0]           op_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 quo_neg;
    logic                 rem_neg;
    logic [CNT_W-1:0]     cnt;

    logic                 accept;
    logic                 is_div;
    logic                 div_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [W-1:0]         a_mag;
    logic [W-1:0]         b_mag;
    logic                 b_zero;
    logic                 div_ovf;
    logic [W-1:0]         special_res;

    logic [W-1:0]         mul_a;
    logic [W-1:0]         mul_b;
    logic [1:0]           mul_op;
    logic                 mul_sa;
    logic                 mul_sb;
    logic [2*W-1:0]       mul_ax;
    logic [2*W-1:0]       mul_bx;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         mul_res;

    logic [W:0]           rem_shift;
    logic [W:0]           diff;
    logic [W-1:0]         div_res;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    assign is_div     = in_op[2];
    assign div_signed = ~in_op[0];
    assign a_neg      = div_signed & operand_A[W-1];
    assign b_neg      = div_signed & operand_B[W-1];
    assign a_mag      = a_neg ? -operand_A : operand_A;
    assign b_mag      = b_neg ? -operand_B : operand_B;
    assign b_zero     = (operand_B == '0);
    assign div_ovf    = div_signed & (operand_A == MOST_NEG) & (operand_B == '1);

    always_comb begin
        special_res = '0;
        if (b_zero)
            special_res = in_op[1] ? operand_A : '1;
        else if (div_ovf)
            special_res = in_op[1] ? '0 : operand_A;
    end

    // With a single-cycle multiply the product is taken straight from the request.
    assign mul_a  = (MULT_LATENCY == 1) ? operand_A : a_q;
    assign mul_b  = (MULT_LATENCY == 1) ? operand_B : b_q;
    assign mul_op = (MULT_LATENCY == 1) ? in_op[1:0] : op_q;
    assign mul_sa = (mul_op != 2'd3);
    assign mul_sb = (mul_op == 2'd1);
    assign mul_ax = {{W{mul_sa & mul_a[W-1]}}, mul_a};
    assign mul_bx = {{W{mul_sb & mul_b[W-1]}}, mul_b};
    assign prod   = mul_ax * mul_bx;
    assign mul_res = (mul_op == 2'd0) ? prod[W-1:0] : prod[2*W-1:W];

    // a_q shifts dividend bits out the top while quotient bits enter at the bottom.
    assign rem_shift = {rem_q, a_q[W-1]};
    assign diff      = rem_shift - {1'b0, b_q};
    assign div_res   = op_q[1] ? (rem_neg ? -rem_q : rem_q)
                               : (quo_neg ? -a_q : a_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            quo_neg    <= 1'b0;
            rem_neg    <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= operand_A;
                        b_q     <= operand_B;
                        op_q    <= in_op[1:0];
                        tag_q   <= in_tag;
                        rem_q   <= '0;
                        cnt     <= '0;
                        quo_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        if (!is_div) begin
                            if (MULT_LATENCY == 1) begin
                                out_result <= mul_res;
                                out_tag    <= in_tag;
                                out_valid  <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                state <= S_MUL;
                            end
                        end else if (b_zero || div_ovf) begin
                            out_result <= special_res;
                            out_tag    <= in_tag;
                            out_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            a_q   <= a_mag;
                            b_q   <= b_mag;
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == MUL_LAST) begin
                        out_result <= mul_res;
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (cnt == DIV_LAST) begin
                        out_result <= div_res;
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!diff[W]) begin
                            rem_q <= diff[W-1:0];
                            a_q   <= {a_q[W-2:0], 1'b1};
                        end else begin
                            rem_q <= rem_shift[W-1:0];
                            a_q   <= {a_q[W-2:0], 1'b0};
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
